ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch front end that drives the program counter into `Instruction_Memory` and consumes its 128-bit line output. It requests one aligned 4-word line at a time, buffers it, and issues single 32-bit instructions to decode over a valid/ready handshake. It also accepts a branch/jump redirect that flushes the buffered line and any read in flight.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address; bits [3:0] are ignored.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  out  32  line address to `Instruction_Memory.pc`; registered; bits [3:0] are always 0.
- `line`  in  128  `Instruction_Memory.out`. It is valid in the cycle after `pc` is sampled. Word k (address pc+4k) is on bits [32k+31:32k].
- `instr`  out  32  instruction to decode.
- `instr_pc`  out  32  byte address of `instr`.
- `instr_valid`  out  1  `instr` and `instr_pc` are valid.
- `instr_ready`  in  1  decode accepts; a transfer happens when valid && ready.
- `redirect`  in  1  single-cycle pulse: restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  target address; bits [1:0] are ignored (treated as 0).

## Operation
- State register: REQ, RESP, ISSUE. Other registers: `buf` (128 bits), `idx` (2 bits), `line_pc` (32 bits).
- Reset (asynchronous): state=REQ, `pc`=`RESET_PC`&~15, `line_pc`=same, `idx`=`RESET_PC`[3:2], `buf`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0.
- REQ: `pc` holds `line_pc`. Next state is RESP.
- RESP: capture `line` into `buf`. Next state is ISSUE.
- ISSUE:
  - Outputs: `instr_valid`=1, `instr`=buf[32·idx+31:32·idx], `instr_pc`=`line_pc`+4·idx.
  - On a transfer with idx<3: idx←idx+1, stay in ISSUE.
  - On a transfer with idx==3: `line_pc`←`line_pc`+16 (wraps modulo 2^32), `pc`←same value, idx←0, next state REQ.
  - Without a transfer, all outputs are held stable.
- `instr_valid`=0 in REQ and RESP. `instr` and `instr_pc` hold their last values there (0 after reset).
- Redirect has the highest priority and applies in any state:
  - `line_pc`←`redirect_pc`&~15, `pc`←same value, idx←`redirect_pc`[3:2], next state REQ.
  - A read in flight is discarded.
  - A transfer completing in the redirect cycle is consumed by decode but does not advance idx.
- No prefetch: a line is requested only after the last word of the previous line is accepted, or on a redirect.

## Timing
- The first rising edge after `rst` falls moves REQ→RESP. The next edge moves RESP→ISSUE. `instr_valid` first rises after the 2nd edge.
- With `instr_ready` held at 1: 4 instructions per 6 cycles, then a 2-cycle bubble (REQ, RESP) per line.
- Redirect sampled at edge E: `instr_valid`=0 for the 2 cycles after E. The target instruction is valid in the 3rd cycle.
- A redirect to word 3 of a line issues 1 instruction, then refetches the next line.
- When `rst` is asserted mid-ISSUE, `instr_valid` drops immediately (asynchronously), not at the next edge.
- `redirect` held for multiple cycles restarts fetch on each cycle. Benches must pulse it for one cycle.

## Test plan
Bench memory model: word at byte address A contains A; the line for `pc`=A is {A+12,A+8,A+4,A}, registered one cycle.
- Reset with `RESET_PC`=0 and `instr_ready`=1 → `pc`=0. Decode receives instr 0,4,8,C with matching `instr_pc`. A 2-cycle gap follows, during which `pc`=16. Then instr 10,14,18,1C are received.
- `instr_ready` toggled 1,0,0,1,… → every instruction is delivered exactly once, in order. `instr` and `instr_pc` stay stable while valid && !ready.
- Redirect to 32'h0000_0108 during the 2nd ISSUE cycle of line 0 → `pc`=32'h100. Valid is low for 2 cycles, then instr 108, 10C are issued, followed by a refetch at `pc`=32'h110.
- Redirect asserted in a RESP cycle → the captured line at the old address is never issued. The first valid instr is the redirect target.
- Redirect to 32'hFFFF_FFFC → one instr FFFF_FFFC is issued, then `pc` wraps to 0 and instr 0 follows.
- `rst` asserted in mid-ISSUE between edges → `instr_valid`=0 immediately. After release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: requests one aligned 4-word line at a time from
// Instruction_Memory, buffers it, and issues single instructions over valid/ready.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic [31:0]  pc,
   input  logic [127:0] line,
   output logic [31:0]  instr,
   output logic [31:0]  instr_pc,
   output logic         instr_valid,
   input  logic         instr_ready,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc
);

   // Handshake: instr/instr_pc are offered while instr_valid is high and must stay
   // stable until instr_ready is seen high at a rising edge (valid && ready = transfer).

   typedef enum logic [1:0] {REQ, RESP, ISSUE} state_t;

   localparam logic [31:0] RESET_LINE = RESET_PC & 32'hFFFF_FFF0;

   state_t        state, state_nxt;
   logic [127:0]  line_buf;
   logic [1:0]    idx, idx_nxt;
   logic [31:0]   line_pc, line_pc_nxt;
   logic [31:0]   instr_hold, pc_hold;
   logic [31:0]   cur_word, cur_pc;
   logic [31:0]   redir_line;
   logic [1:0]    redir_idx;
   logic          capture;
   logic          xfer;

   assign cur_word   = line_buf[{idx, 5'b00000} +: 32];
   assign cur_pc     = line_pc + {28'd0, idx, 2'b00};
   assign redir_line = redirect_pc & 32'hFFFF_FFF0;
   assign redir_idx  = 2'((redirect_pc & 32'h0000_000C) >> 2);
   assign xfer       = (state == ISSUE) && instr_ready;

   always_comb begin
      state_nxt   = state;
      idx_nxt     = idx;
      line_pc_nxt = line_pc;
      capture     = 1'b0;
      case (state)
         REQ:  state_nxt = RESP;
         RESP: begin
            capture   = 1'b1;
            state_nxt = ISSUE;
         end
         ISSUE: begin
            if (xfer) begin
               if (idx == 2'd3) begin
                  line_pc_nxt = line_pc + 32'd16;
                  idx_nxt     = 2'd0;
                  state_nxt   = REQ;
               end else begin
                  idx_nxt = idx + 2'd1;
               end
            end
         end
         default: state_nxt = REQ;
      endcase
      // Redirect overrides everything; a line arriving this cycle is dropped.
      if (redirect) begin
         line_pc_nxt = redir_line;
         idx_nxt     = redir_idx;
         state_nxt   = REQ;
         capture     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= REQ;
         line_pc    <= RESET_LINE;
         idx        <= RESET_PC[3:2];
         line_buf   <= '0;
         instr_hold <= '0;
         pc_hold    <= '0;
      end else begin
         state   <= state_nxt;
         line_pc <= line_pc_nxt;
         idx     <= idx_nxt;
         if (capture) begin
            line_buf <= line;
         end
         if (state == ISSUE) begin
            instr_hold <= cur_word;
            pc_hold    <= cur_pc;
         end
      end
   end

   // line_pc is the registered line address, so pc needs no separate flop.
   assign pc          = line_pc;
   assign instr_valid = (state == ISSUE);
   assign instr       = (state == ISSUE) ? cur_word : instr_hold;
   assign instr_pc    = (state == ISSUE) ? cur_pc   : pc_hold;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: memory model returns each word's own address, a stream
// model checks every transfer, and directed sequences pin cycle timing.
module tb_ifetch_unit;

   logic          clk;
   logic          rst;
   logic [31:0]   pc;
   logic [127:0]  line;
   logic [31:0]   instr;
   logic [31:0]   instr_pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          redirect;
   logic [31:0]   redirect_pc;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_xfer  = 0;
   logic [31:0]   exp_addr = 32'h0;
   logic          prev_hold = 1'b0;
   logic          prev_redir = 1'b0;
   logic [31:0]   prev_instr = 32'h0;
   logic [31:0]   prev_ipc = 32'h0;

   logic          t1_valid [12] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
   logic [31:0]   t1_instr [12] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC,
                                    32'hC, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
   logic [31:0]   t1_pc [12]    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                    32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 32'h10};

   ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .line        (line),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: registered, each word holds its own byte address.
   logic [127:0] line_mem = '0;
   always @(posedge clk) line_mem <= {pc + 32'd12, pc + 32'd8, pc + 32'd4, pc};
   assign line = line_mem;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      exp_addr = 32'h0;
   endtask

   task automatic pulse_redirect(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      tick();
      redirect    = 1'b0;
   endtask

   // Stream model: decode must see consecutive word addresses, restarting at
   // each redirect target; offered values stay stable while stalled.
   always @(negedge clk) begin
      if (!rst) begin
         if (instr_valid && instr_ready) begin
            chk("xfer_instr", instr, exp_addr);
            chk("xfer_instr_pc", instr_pc, exp_addr);
            exp_addr = exp_addr + 32'd4;
            n_xfer++;
         end
         if (prev_hold && !prev_redir) begin
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_instr", instr, prev_instr);
            chk("stall_instr_pc", instr_pc, prev_ipc);
         end
         if (redirect) exp_addr = redirect_pc & 32'hFFFF_FFFC;
         prev_hold  = instr_valid && !instr_ready;
         prev_redir = redirect;
         prev_instr = instr;
         prev_ipc   = instr_pc;
      end else begin
         prev_hold = 1'b0;
      end
   end

   initial begin
      int start;
      rst         = 1'b1;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      #2;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc", pc, 32'h0);

      // Sequential fetch of two lines with decode always ready.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         if (c > 0) tick();
         chk("t1_valid", {31'd0, instr_valid}, {31'd0, t1_valid[c]});
         chk("t1_instr", instr, t1_instr[c]);
         chk("t1_instr_pc", instr_pc, t1_instr[c]);
         chk("t1_pc", pc, t1_pc[c]);
      end

      // Backpressure pattern 1,0,0,1 repeating.
      start = n_xfer;
      for (int i = 0; i < 48; i++) begin
         instr_ready = ((i % 4) == 0) || ((i % 4) == 3);
         tick();
      end
      instr_ready = 1'b1;
      chk("t2_progress", {31'd0, (n_xfer - start) > 8}, 32'd1);

      // Redirect to 0x108 in the second ISSUE cycle of line 0.
      do_reset();
      tick();
      tick();
      tick();
      chk("t3_pre_instr", instr, 32'h4);
      pulse_redirect(32'h0000_0108);
      chk("t3_pc", pc, 32'h100);
      chk("t3_gap0", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("t3_gap1", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("t3_valid", {31'd0, instr_valid}, 32'd1);
      chk("t3_instr0", instr, 32'h108);
      tick();
      chk("t3_instr1", instr, 32'h10C);
      tick();
      chk("t3_refetch_valid", {31'd0, instr_valid}, 32'd0);
      chk("t3_refetch_pc", pc, 32'h110);

      // Redirect during RESP: the line at address 0 must never be issued.
      do_reset();
      tick();
      pulse_redirect(32'h0000_0040);
      chk("t4_pc", pc, 32'h40);
      chk("t4_gap0", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("t4_gap1", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("t4_first", instr, 32'h40);
      chk("t4_first_pc", instr_pc, 32'h40);

      // Redirect to the last word of the address space, then wrap to 0.
      do_reset();
      pulse_redirect(32'hFFFF_FFFC);
      chk("t5_pc", pc, 32'hFFFF_FFF0);
      tick();
      tick();
      chk("t5_instr", instr, 32'hFFFF_FFFC);
      chk("t5_valid", {31'd0, instr_valid}, 32'd1);
      tick();
      chk("t5_wrap_valid", {31'd0, instr_valid}, 32'd0);
      chk("t5_wrap_pc", pc, 32'h0);
      tick();
      tick();
      chk("t5_after_wrap", instr, 32'h0);

      // Asynchronous reset in the middle of an ISSUE cycle.
      instr_ready = 1'b0;
      do_reset();
      tick();
      tick();
      chk("t6_pre_valid", {31'd0, instr_valid}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", {31'd0, instr_valid}, 32'd0);
      chk("t6_async_pc", pc, 32'h0);
      instr_ready = 1'b1;
      do_reset();
      chk("t6_restart_pc", pc, 32'h0);
      tick();
      tick();
      chk("t6_restart_instr", instr, 32'h0);
      chk("t6_restart_valid", {31'd0, instr_valid}, 32'd1);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
